// File: rtl/tone_player.sv
// tone_player: square-wave generator driven by a half-period count.
// A key press (en=1) starts a note and releasing the key ends it. A new tone
// takes effect only at the start of a full period (the rising edge of
// speaker), and a note always ends with speaker low, so the pin never
// produces a runt pulse.
//
// Optional feature: when TONE_PLAYER_OCTAVE_EN is defined, the module gains
// an octave_up input. It is sampled together with tone, and when it is 1 the
// half-period count used is tone>>1 (roughly one octave higher).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           note request (1 while any key is held)
//   tone         half-period length minus 1, in clk cycles
//   octave_up    (TONE_PLAYER_OCTAVE_EN only) halve the sampled tone
//   speaker      square-wave output (registered)
//   busy         1 while the player is not idle (registered)
//   period_tick  1-cycle pulse on each rising edge of speaker (registered)
module tone_player #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] tone,
`ifdef TONE_PLAYER_OCTAVE_EN
  input  logic             octave_up,
`endif
  output logic             speaker,
  output logic             busy,
  output logic             period_tick
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] tone_q, tone_q_nxt;
  logic             speaker_nxt;
  logic             tick_nxt;
  logic [WIDTH-1:0] tone_eff;

  // Tone value as it would be captured at a note start or rising point.
`ifdef TONE_PLAYER_OCTAVE_EN
  assign tone_eff = octave_up ? (tone >> 1) : tone;
`else
  assign tone_eff = tone;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      tone_q      <= '0;
      speaker     <= 1'b0;
      busy        <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      tone_q      <= tone_q_nxt;
      speaker     <= speaker_nxt;
      busy        <= (state_nxt != IDLE);
      period_tick <= tick_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tone_q_nxt  = tone_q;
    speaker_nxt = speaker;
    tick_nxt    = 1'b0;

    case (state)
      IDLE: begin
        speaker_nxt = 1'b0;
        if (en) begin
          state_nxt   = PLAY;
          tone_q_nxt  = tone_eff;
          cnt_nxt     = tone_eff;
          speaker_nxt = 1'b1;
          tick_nxt    = 1'b1;
        end
      end

      PLAY: begin
        if (!en) begin
          // Release takes priority over an expiring half-period.
          if (!speaker) begin
            state_nxt = IDLE;
          end else if (cnt == '0) begin
            state_nxt   = IDLE;
            speaker_nxt = 1'b0;
          end else begin
            state_nxt = STOP;
            cnt_nxt   = cnt - WIDTH'(1);
          end
        end else if (cnt != '0) begin
          cnt_nxt = cnt - WIDTH'(1);
        end else if (speaker) begin
          speaker_nxt = 1'b0;
          cnt_nxt     = tone_q;
        end else begin
          // Rising point: the only place a new tone is picked up.
          speaker_nxt = 1'b1;
          tone_q_nxt  = tone_eff;
          cnt_nxt     = tone_eff;
          tick_nxt    = 1'b1;
        end
      end

      STOP: begin
        // Finish the high half regardless of en, then fall to idle.
        if (cnt != '0) begin
          cnt_nxt = cnt - WIDTH'(1);
        end else begin
          speaker_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end

      default: begin
        state_nxt   = IDLE;
        speaker_nxt = 1'b0;
      end
    endcase
  end

endmodule
